// File: rtl/exc_sequencer_pkg.sv
// Shared encodings for the CP0 exception sequencer: CP0 BEGIN/END control
// codes, MIPS ExcCode values and the sequencer state type.
package exc_sequencer_pkg;

  typedef enum logic [1:0] {
    CTRL_NONE  = 2'b00,
    CTRL_BEGIN = 2'b01,
    CTRL_END   = 2'b10
  } ext_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTER,
    S_LEAVE,
    S_DRAIN
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_sequencer.sv
// Picks one exception/interrupt/ERET event per cycle from the M stage, drives
// CP0 BEGIN/END, flushes and redirects the pipeline, then holds until drained.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic        int_req,
  input  logic [31:0] epc,
  output logic [1:0]  ext_int_control,
  output logic [4:0]  ext_code,
  output logic        bd_op,
  output logic [31:0] cp0_pc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  ext_ctrl_e   ctrl_q, ctrl_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] cp0_pc_q, cp0_pc_d;
  logic        flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  // NOTE: every signal is given a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    ctrl_d        = CTRL_NONE;
    code_d        = code_q;
    bd_d          = bd_q;
    cp0_pc_d      = cp0_pc_q;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    unique case (state_q)
      S_IDLE: begin
        // Synchronous exception outranks the interrupt; both outrank ERET.
        if (m_valid && (m_exc || int_req)) begin
          state_d       = S_ENTER;
          ctrl_d        = CTRL_BEGIN;
          code_d        = m_exc ? m_exc_code : EXC_INT;
          bd_d          = m_bd;
          cp0_pc_d      = m_pc;
          flush_d       = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = HANDLER_PC;
        end else if (m_valid && m_eret) begin
          state_d       = S_LEAVE;
          ctrl_d        = CTRL_END;
          flush_d       = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = epc & 32'hFFFF_FFFC;
        end
      end
      S_ENTER, S_LEAVE: begin
        state_d = S_DRAIN;
        drain_d = DRAIN_LOAD;
        flush_d = 1'b1;
      end
      S_DRAIN: begin
        // M-stage inputs belong to flushed instructions here and are ignored.
        if (drain_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      drain_q       <= 4'd0;
      ctrl_q        <= CTRL_NONE;
      code_q        <= 5'd0;
      bd_q          <= 1'b0;
      cp0_pc_q      <= 32'd0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      ctrl_q        <= ctrl_d;
      code_q        <= code_d;
      bd_q          <= bd_d;
      cp0_pc_q      <= cp0_pc_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign ext_int_control = ctrl_q;
  assign ext_code        = code_q;
  assign bd_op           = bd_q;
  assign cp0_pc          = cp0_pc_q;
  assign flush           = flush_q;
  assign redirect        = redirect_q;
  assign redirect_pc     = redirect_pc_q;
  assign busy            = busy_q;

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Sequences exception/interrupt entry and ERET exit for the CP0 block of the 5-stage MIPS pipeline.
- Samples the M-stage exception status and the CP0 interrupt request, then picks one winner per cycle.
- Drives the CP0 BEGIN/END control, exception code, BD flag and victim PC.
- Issues the pipeline flush and the PC redirect to the handler or to EPC, then holds off new events until the pipeline has drained.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address.
- DRAIN_CYCLES, 3, flush-hold cycles after a redirect (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_valid  in  1  M stage holds a real instruction (not a bubble)
- m_pc  in  32  PC of the M-stage instruction
- m_bd  in  1  M-stage instruction sits in a branch delay slot
- m_exc  in  1  M-stage instruction raised a synchronous exception
- m_exc_code  in  5  ExcCode of that exception
- m_eret  in  1  M-stage instruction is ERET
- int_req  in  1  CP0 IntReq (already masked by IM/IE/EXL)
- epc  in  32  CP0 EPC_OUT
- ext_int_control  out  2  to CP0: 00 NONE, 01 BEGIN, 10 END
- ext_code  out  5  to CP0 Ext_code
- bd_op  out  1  to CP0 BDop
- cp0_pc  out  32  to CP0 PC
- flush  out  1  kill F/D/E/M pipeline registers
- redirect  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  32  next fetch address
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. Reset values:
  - ext_int_control=00, ext_code=0, bd_op=0, cp0_pc=0
  - flush=0, redirect=0, redirect_pc=0, busy=0
  - state=IDLE, drain counter=0
- States: IDLE, ENTER, LEAVE, DRAIN.
- In IDLE, the decision is evaluated every cycle with fixed priority:
  1. m_valid&m_exc -> ENTER, ext_code=m_exc_code.
  2. Else m_valid&int_req -> ENTER, ext_code=0 (Int).
  3. Else m_valid&m_eret -> LEAVE.
  4. Else stay in IDLE.
- Interrupts are taken only when m_valid=1. A bubble in M defers the interrupt; it is never dropped while int_req stays high.
- ENTER, one cycle:
  - ext_int_control=01, cp0_pc=m_pc latched at decision, bd_op=m_bd latched.
  - flush=1, redirect=1, redirect_pc=HANDLER_PC.
  - Next state is DRAIN.
  - CP0 itself applies PC-4 when BD=1. This block never adjusts the PC.
- LEAVE, one cycle:
  - ext_int_control=10, flush=1, redirect=1.
  - redirect_pc={epc[31:2],2'b00}, with epc sampled at decision.
  - Next state is DRAIN.
- DRAIN:
  - flush=1, redirect=0, ext_int_control=00.
  - The counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 the next state is IDLE.
  - All m_* and int_req inputs are ignored in DRAIN (they belong to flushed instructions).
- Latency: decision cycle N -> BEGIN/END and redirect in cycle N+1 -> CP0 updates at the N+1 edge -> back in IDLE at N+2+DRAIN_CYCLES.
- Exceptions are taken even when EXL=1, because exception entry does not depend on EXL. Interrupts are blocked by int_req gating.
- When exception and ERET are both present on the same instruction, the exception wins.
- Reset mid-sequence returns to IDLE with all outputs deasserted on the next edge. No partial BEGIN is emitted.

Decomposition:
- Shared package/header (head.v): the ext_int_control encodings NONE/BEGIN/END and the ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- Sub-module: none required. A separate priority encoder (exc_prio) is allowed if more exception sources are added later.

Test Plan:
- Overflow: m_valid=1, m_exc=1, m_exc_code=12, m_pc=0x3010, m_bd=0.
  - Next cycle: ext_int_control=01, ext_code=12, cp0_pc=0x3010, redirect_pc=0x4180, flush=1.
  - busy falls 1+DRAIN_CYCLES cycles later.
- Delay-slot interrupt: int_req=1, m_valid=1, m_pc=0x3024, m_bd=1 -> ext_code=0, bd_op=1, cp0_pc=0x3024.
- Deferred interrupt: int_req=1 with m_valid=0 for 3 cycles, then m_valid=1 -> ENTER only after m_valid rises, with no output activity before it.
- ERET: m_eret=1, epc=0x3033 -> ext_int_control=10, redirect_pc=0x3030, flush=1.
- Priority and drain blocking:
  - m_exc=1 and int_req=1 together -> ext_code=m_exc_code.
  - A new m_exc during DRAIN is ignored: exactly one BEGIN is seen.
- Reset: assert reset during DRAIN -> all outputs return to 0 and state=IDLE next cycle.
